// File: rtl/keypad_scan_pkg.sv
// Shared types for the keypad scanner: FSM states, snapshot classes, key codes
// and the snapshot classifier.
package keypad_scan_pkg;

  localparam int COL_W = 4;
  localparam int ROW_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SNAP_NONE  = 2'd0,
    SNAP_ONE   = 2'd1,
    SNAP_MULTI = 2'd2
  } snap_class_t;

  // Key codes are row*4 + col, as decoded by the clock controller.
  typedef enum logic [3:0] {
    KEY_0,  KEY_1,  KEY_2,  KEY_3,
    KEY_4,  KEY_5,  KEY_6,  KEY_7,
    KEY_8,  KEY_9,  KEY_10, KEY_11,
    KEY_12, KEY_13, KEY_14, KEY_15
  } key_t;

  typedef struct packed {
    snap_class_t cls;
    key_t        code;
  } snap_info_t;

  // Snapshot bit index is col*4 + row; the key code swaps the two fields.
  function automatic snap_info_t classify(input logic [15:0] snap);
    snap_info_t  info;
    int          n;
    logic [3:0]  idx;
    info.cls  = SNAP_NONE;
    info.code = KEY_0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        n++;
        idx = 4'(i);
        info.code = key_t'({idx[1:0], idx[3:2]});
      end
    end
    if (n == 1)
      info.cls = SNAP_ONE;
    else if (n > 1)
      info.cls = SNAP_MULTI;
    return info;
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every DWELL clocks.
module scan_tick_gen #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int W = (DWELL > 2) ? $clog2(DWELL) : 1;

  logic [W-1:0] cnt;

  assign o_tick = (cnt == W'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (o_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, full-snapshot capture, debounce FSM and
// one-pulse-per-press key event output.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int DEB_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] i_row,
  output logic [COL_W-1:0] o_col,
  output logic [3:0]       o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held
);

  localparam int         DWELL    = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] DEB_LAST = 4'(DEB_SCANS - 1);

  logic        tick;
  logic [1:0]  col;
  logic [1:0]  col_nxt;
  logic [15:0] snap;
  logic [15:0] snap_now;
  logic [15:0] prev_snap;
  logic        scan_done;
  logic        same_snap;
  snap_info_t  info;
  state_t      state;
  logic [3:0]  deb_cnt;
  key_t        cand;

  scan_tick_gen #(.DWELL(DWELL)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // Snapshot as it will look once the current column is captured.
  always_comb begin
    snap_now = snap;
    snap_now[{col, 2'b00} +: 4] = ~i_row;
  end

  assign col_nxt   = col + 2'd1;
  assign scan_done = tick && (col == 2'd3);
  assign info      = classify(snap_now);
  assign same_snap = (snap_now == prev_snap);

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= 2'd0;
      o_col       <= 4'b1110;
      snap        <= '0;
      prev_snap   <= '0;
      state       <= ST_IDLE;
      deb_cnt     <= '0;
      cand        <= KEY_0;
      o_key_code  <= '0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (tick) begin
        snap  <= snap_now;
        col   <= col_nxt;
        o_col <= ~(4'b0001 << col_nxt);
      end
      if (scan_done) begin
        prev_snap <= snap_now;
        case (state)
          ST_IDLE: begin
            if (info.cls == SNAP_ONE) begin
              cand <= info.code;
              if (DEB_LAST == 4'd0) begin
                state       <= ST_PRESSED;
                deb_cnt     <= '0;
                o_key_code  <= info.code;
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
              end else begin
                state   <= ST_DEB_PRESS;
                deb_cnt <= 4'd1;
              end
            end
          end
          ST_DEB_PRESS: begin
            if (info.cls != SNAP_ONE) begin
              state   <= ST_IDLE;
              deb_cnt <= '0;
            end else if (!same_snap) begin
              cand    <= info.code;
              deb_cnt <= 4'd1;
            end else if (deb_cnt >= DEB_LAST) begin
              state       <= ST_PRESSED;
              deb_cnt     <= '0;
              o_key_code  <= cand;
              o_key_valid <= 1'b1;
              o_key_held  <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end
          ST_PRESSED: begin
            if (!(info.cls == SNAP_ONE && info.code == cand)) begin
              if (DEB_LAST == 4'd0 && info.cls == SNAP_NONE) begin
                state      <= ST_IDLE;
                deb_cnt    <= '0;
                o_key_held <= 1'b0;
              end else begin
                state   <= ST_DEB_REL;
                deb_cnt <= 4'd1;
              end
            end
          end
          ST_DEB_REL: begin
            if (info.cls == SNAP_NONE) begin
              if (deb_cnt >= DEB_LAST) begin
                state      <= ST_IDLE;
                deb_cnt    <= '0;
                o_key_held <= 1'b0;
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else if (info.cls == SNAP_ONE && info.code == cand) begin
              state   <= ST_PRESSED;
              deb_cnt <= '0;
            end else begin
              deb_cnt <= 4'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            deb_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix on the row lines.
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  i_row;
  logic [3:0]  o_col;
  logic [3:0]  o_key_code;
  logic        o_key_valid;
  logic        o_key_held;

  logic [15:0] keys;          // indexed by row*4 + col
  int          pulses;
  logic [3:0]  last_code;
  int          compared;
  int          mismatched;
  int          base;
  int          waited;

  keypad_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .DEB_SCANS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_row       (i_row),
    .o_col       (o_col),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low when any pressed key on it sits in the driven column.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !o_col[c])
          i_row[r] = 1'b0;
  end

  // Counts every cycle valid is high, so a stretched pulse shows as extra pulses.
  initial begin
    pulses    = 0;
    last_code = 4'h0;
  end
  always @(negedge clk) begin
    if (o_key_valid) begin
      pulses++;
      last_code = o_key_code;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int b, input int max, output int n);
    n = 0;
    while (pulses == b && n < max) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_release(input int max, output int n);
    n = 0;
    while (o_key_held && n < max) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    keys       = '0;
    rst        = 1'b1;

    // 1. reset state and column walk
    step(3);
    rst = 1'b0;
    check("rst_col", 16'(o_col), 16'h000E);
    check("rst_code", 16'(o_key_code), 16'h0);
    check("rst_valid", 16'(o_key_valid), 16'h0);
    check("rst_held", 16'(o_key_held), 16'h0);
    step(9);
    check("col0_dwell", 16'(o_col), 16'h000E);
    step(1);
    check("col1", 16'(o_col), 16'h000D);
    step(10);
    check("col2", 16'(o_col), 16'h000B);
    step(10);
    check("col3", 16'(o_col), 16'h0007);
    step(10);
    check("col_wrap", 16'(o_col), 16'h000E);
    check("idle_no_pulse", 16'(pulses), 16'h0);
    check("idle_held", 16'(o_key_held), 16'h0);
    step(15);
    rst = 1'b1;
    step(1);
    check("midscan_rst_col", 16'(o_col), 16'h000E);
    rst = 1'b0;

    // 2. single key row2/col1 held for 1000 cycles
    step(7);
    base = pulses;
    keys[9] = 1'b1;
    wait_pulse(base, 160, waited);
    check("k9_latency_ok", 16'(pulses - base), 16'h1);
    check("k9_code", 16'(last_code), 16'h9);
    step(1000 - waited);
    check("k9_one_pulse", 16'(pulses - base), 16'h1);
    check("k9_held", 16'(o_key_held), 16'h1);
    check("k9_code_hold", 16'(o_key_code), 16'h9);
    keys[9] = 1'b0;
    wait_release(160, waited);
    check("k9_released", 16'(o_key_held), 16'h0);
    check("k9_code_kept", 16'(o_key_code), 16'h9);

    // 3. bouncing key row1/col2, phase fixed by a reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    base = pulses;
    for (int m = 0; m < 100; m++) begin
      keys[6] = ((m / 7) % 2 == 0);
      step(1);
    end
    keys[6] = 1'b1;
    check("bounce_no_pulse", 16'(pulses - base), 16'h0);
    wait_pulse(base, 160, waited);
    check("bounce_pulse", 16'(pulses - base), 16'h1);
    check("bounce_code", 16'(last_code), 16'h6);
    step(40);
    check("bounce_single", 16'(pulses - base), 16'h1);
    keys[6] = 1'b0;
    wait_release(160, waited);
    check("bounce_released", 16'(o_key_held), 16'h0);

    // 4. two keys together, then one released
    step(13);
    base = pulses;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    step(300);
    check("multi_no_pulse", 16'(pulses - base), 16'h0);
    check("multi_not_held", 16'(o_key_held), 16'h0);
    keys[0] = 1'b0;
    wait_pulse(base, 160, waited);
    check("multi_after_pulse", 16'(pulses - base), 16'h1);
    check("multi_after_code", 16'(last_code), 16'h5);
    keys[5] = 1'b0;
    wait_release(160, waited);
    check("multi_released", 16'(o_key_held), 16'h0);

    // 5. press lasting one scan is rejected
    step(21);
    base = pulses;
    keys[15] = 1'b1;
    step(40);
    keys[15] = 1'b0;
    step(200);
    check("short_no_pulse", 16'(pulses - base), 16'h0);
    check("short_not_held", 16'(o_key_held), 16'h0);
    check("short_code_kept", 16'(o_key_code), 16'h5);

    // 6. reset while pressed, key kept down
    base = pulses;
    keys[10] = 1'b1;
    wait_pulse(base, 160, waited);
    check("k10_pulse", 16'(pulses - base), 16'h1);
    step(3);
    check("k10_held", 16'(o_key_held), 16'h1);
    rst = 1'b1;
    step(1);
    check("rst_pressed_held", 16'(o_key_held), 16'h0);
    check("rst_pressed_code", 16'(o_key_code), 16'h0);
    check("rst_pressed_col", 16'(o_col), 16'h000E);
    rst = 1'b0;
    base = pulses;
    wait_pulse(base, 200, waited);
    check("redeb_pulse", 16'(pulses - base), 16'h1);
    check("redeb_code", 16'(last_code), 16'hA);
    keys[10] = 1'b0;
    wait_release(160, waited);
    check("redeb_released", 16'(o_key_held), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
